// File: rtl/bcd_pair_counter.sv
// bcd_pair_counter: two-digit BCD up/down counter with parallel load.
//
// Counts 0..MODULUS-1 and wraps in both directions. A load applies only when
// both digits are valid BCD and the loaded value is below MODULUS; otherwise
// the count holds and LoadError pulses. Priority each edge: Load > Enable > hold.
//
// Ports
//   Clock      in   1  rising-edge clock
//   ResetN     in   1  asynchronous active-low reset
//   Load       in   1  load LoadT/LoadO this cycle
//   LoadT      in   4  tens digit to load
//   LoadO      in   4  ones digit to load
//   Enable     in   1  count one step this cycle
//   Up         in   1  1 = increment, 0 = decrement
//   YT         out  4  tens digit (registered)
//   YO         out  4  ones digit (registered)
//   Carry      out  1  pulse on up-wrap to 00
//   Borrow     out  1  pulse on down-wrap to MODULUS-1
//   LoadError  out  1  pulse on rejected load
module bcd_pair_counter #(
  parameter int unsigned MODULUS = 100  // legal 2..100
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       Load,
  input  logic [3:0] LoadT,
  input  logic [3:0] LoadO,
  input  logic       Enable,
  input  logic       Up,
  output logic [3:0] YT,
  output logic [3:0] YO,
  output logic       Carry,
  output logic       Borrow,
  output logic       LoadError
);

  // Digits of the top count value MODULUS-1.
  localparam logic [3:0] MaxT   = 4'((MODULUS - 1) / 10);
  localparam logic [3:0] MaxO   = 4'((MODULUS - 1) % 10);
  localparam logic [7:0] ModVal = 8'(MODULUS);

  logic [3:0] yt_q, yt_d;
  logic [3:0] yo_q, yo_d;
  logic       carry_q, carry_d;
  logic       borrow_q, borrow_d;
  logic       load_error_q, load_error_d;

  logic [7:0] load_val;
  logic       load_ok;
  logic       at_max;
  logic       at_zero;

  // Max operands 15*10+15 = 165, so 8 bits never overflow.
  assign load_val = ({4'b0, LoadT} * 8'd10) + {4'b0, LoadO};
  assign load_ok  = (LoadT <= 4'd9) && (LoadO <= 4'd9) && (load_val < ModVal);
  assign at_max   = (yt_q == MaxT) && (yo_q == MaxO);
  assign at_zero  = (yt_q == 4'd0) && (yo_q == 4'd0);

  always_comb begin
    yt_d         = yt_q;
    yo_d         = yo_q;
    carry_d      = 1'b0;
    borrow_d     = 1'b0;
    load_error_d = 1'b0;

    if (Load) begin
      if (load_ok) begin
        yt_d = LoadT;
        yo_d = LoadO;
      end else begin
        load_error_d = 1'b1;
      end
    end else if (Enable) begin
      if (Up) begin
        if (at_max) begin
          yt_d    = 4'd0;
          yo_d    = 4'd0;
          carry_d = 1'b1;
        end else if (yo_q == 4'd9) begin
          yo_d = 4'd0;
          yt_d = yt_q + 4'd1;
        end else begin
          yo_d = yo_q + 4'd1;
        end
      end else begin
        if (at_zero) begin
          yt_d     = MaxT;
          yo_d     = MaxO;
          borrow_d = 1'b1;
        end else if (yo_q == 4'd0) begin
          yo_d = 4'd9;
          yt_d = yt_q - 4'd1;
        end else begin
          yo_d = yo_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      yt_q         <= 4'd0;
      yo_q         <= 4'd0;
      carry_q      <= 1'b0;
      borrow_q     <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      yt_q         <= yt_d;
      yo_q         <= yo_d;
      carry_q      <= carry_d;
      borrow_q     <= borrow_d;
      load_error_q <= load_error_d;
    end
  end

  assign YT        = yt_q;
  assign YO        = yo_q;
  assign Carry     = carry_q;
  assign Borrow    = borrow_q;
  assign LoadError = load_error_q;

endmodule

// File: tb/tb_bcd_pair_counter.sv
// Bench for bcd_pair_counter: one instance at MODULUS=100 and one at MODULUS=60
// share the same stimulus. An integer-valued reference model predicts both per
// edge; predictions are queued when stimulus is driven and popped after the edge.
module tb_bcd_pair_counter;

  typedef struct packed {
    logic [3:0] yt;
    logic [3:0] yo;
    logic       carry;
    logic       borrow;
    logic       lerr;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] load_t;
  logic [3:0] load_o;
  logic       enable;
  logic       up;

  logic [3:0] yt_a, yo_a, yt_b, yo_b;
  logic       carry_a, borrow_a, lerr_a;
  logic       carry_b, borrow_b, lerr_b;

  int   n_vec;
  int   n_err;
  int   v100;
  int   v60;
  exp_t sb_q[$];

  bcd_pair_counter #(.MODULUS(100)) dut100 (
    .Clock     (clk),
    .ResetN    (rst_n),
    .Load      (load),
    .LoadT     (load_t),
    .LoadO     (load_o),
    .Enable    (enable),
    .Up        (up),
    .YT        (yt_a),
    .YO        (yo_a),
    .Carry     (carry_a),
    .Borrow    (borrow_a),
    .LoadError (lerr_a)
  );

  bcd_pair_counter #(.MODULUS(60)) dut60 (
    .Clock     (clk),
    .ResetN    (rst_n),
    .Load      (load),
    .LoadT     (load_t),
    .LoadO     (load_o),
    .Enable    (enable),
    .Up        (up),
    .YT        (yt_b),
    .YO        (yo_b),
    .Carry     (carry_b),
    .Borrow    (borrow_b),
    .LoadError (lerr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model working on the integer value, not on digits.
  task automatic model(input int m, input bit ld, input int lt, input int lo,
                       input bit en, input bit u, inout int v, output exp_t x);
    x = '0;
    if (ld) begin
      if (lt <= 9 && lo <= 9 && (lt * 10 + lo) < m) v = lt * 10 + lo;
      else x.lerr = 1'b1;
    end else if (en) begin
      if (u) begin
        if (v == m - 1) begin
          v = 0;
          x.carry = 1'b1;
        end else begin
          v = v + 1;
        end
      end else begin
        if (v == 0) begin
          v = m - 1;
          x.borrow = 1'b1;
        end else begin
          v = v - 1;
        end
      end
    end
    x.yt = 4'(v / 10);
    x.yo = 4'(v % 10);
  endtask

  // Drive one cycle of stimulus, push predictions, clock, then pop and compare.
  task automatic apply(input string name, input bit ld, input int lt, input int lo,
                       input bit en, input bit u);
    exp_t x, ea, eb, oa, ob;
    load   = ld;
    load_t = 4'(lt);
    load_o = 4'(lo);
    enable = en;
    up     = u;
    model(100, ld, lt, lo, en, u, v100, x);
    sb_q.push_back(x);
    model(60, ld, lt, lo, en, u, v60, x);
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    ea = sb_q.pop_front();
    eb = sb_q.pop_front();
    oa = '{yt: yt_a, yo: yo_a, carry: carry_a, borrow: borrow_a, lerr: lerr_a};
    ob = '{yt: yt_b, yo: yo_b, carry: carry_b, borrow: borrow_b, lerr: lerr_b};
    n_vec++;
    if (oa !== ea) begin
      n_err++;
      $display("FAIL %s m100: got YT=%0d YO=%0d C=%b B=%b E=%b, want YT=%0d YO=%0d C=%b B=%b E=%b",
               name, oa.yt, oa.yo, oa.carry, oa.borrow, oa.lerr,
               ea.yt, ea.yo, ea.carry, ea.borrow, ea.lerr);
    end
    n_vec++;
    if (ob !== eb) begin
      n_err++;
      $display("FAIL %s m60: got YT=%0d YO=%0d C=%b B=%b E=%b, want YT=%0d YO=%0d C=%b B=%b E=%b",
               name, ob.yt, ob.yo, ob.carry, ob.borrow, ob.lerr,
               eb.yt, eb.yo, eb.carry, eb.borrow, eb.lerr);
    end
  endtask

  // Outputs must all read zero while reset is held, with no clock edge needed.
  task automatic check_zero(input string name);
    n_vec++;
    if ({yt_a, yo_a, carry_a, borrow_a, lerr_a, yt_b, yo_b, carry_b, borrow_b, lerr_b}
        !== 15'd0 || {yt_b, yo_b} !== 8'd0) begin
      n_err++;
      $display("FAIL %s: got m100 %0d%0d %b%b%b m60 %0d%0d %b%b%b, want all zero",
               name, yt_a, yo_a, carry_a, borrow_a, lerr_a,
               yt_b, yo_b, carry_b, borrow_b, lerr_b);
    end
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    @(posedge clk);
    #1;
    check_zero("reset_held");
    rst_n = 1'b1;
    v100 = 0;
    v60  = 0;
    apply("reset_hold", 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_up_wrap();
    apply("up_load97", 1'b1, 9, 7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) apply("up_wrap", 1'b0, 0, 0, 1'b1, 1'b1);
  endtask

  task automatic test_down_wrap();
    apply("dn_load01", 1'b1, 0, 1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) apply("dn_wrap", 1'b0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic test_load_priority();
    apply("prio_load20", 1'b1, 2, 0, 1'b0, 1'b0);
    apply("prio_load45", 1'b1, 4, 5, 1'b1, 1'b1);
    apply("prio_hold", 1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  task automatic test_load_reject();
    apply("rej_bad_ones", 1'b1, 4, 10, 1'b0, 1'b0);
    apply("rej_bad_tens", 1'b1, 12, 0, 1'b1, 1'b1);
    apply("rej_ff", 1'b1, 15, 15, 1'b0, 1'b0);
    apply("rej_after", 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_modulus60();
    apply("m60_load59", 1'b1, 5, 9, 1'b0, 1'b0);
    apply("m60_up", 1'b0, 0, 0, 1'b1, 1'b1);
    apply("m60_down", 1'b0, 0, 0, 1'b1, 1'b0);
    apply("m60_load60", 1'b1, 6, 0, 1'b0, 1'b0);
    apply("m60_load99", 1'b1, 9, 9, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_count();
    apply("rst_load33", 1'b1, 3, 3, 1'b0, 1'b0);
    apply("rst_up", 1'b0, 0, 0, 1'b1, 1'b1);
    load   = 1'b0;
    enable = 1'b1;
    up     = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    rst_n = 1'b1;
    v100 = 0;
    v60  = 0;
    apply("rst_resume", 1'b0, 0, 0, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    // Full laps so every wrap pulse is checked, including repeated ones.
    apply("b2b_load00", 1'b1, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 205; i++) apply("b2b_up", 1'b0, 0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 205; i++) apply("b2b_down", 1'b0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      apply("b2b_rand", ($urandom_range(0, 7) == 0), $urandom_range(0, 11),
            $urandom_range(0, 11), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    v100   = 0;
    v60    = 0;
    rst_n  = 1'b1;
    load   = 1'b0;
    load_t = 4'd0;
    load_o = 4'd0;
    enable = 1'b0;
    up     = 1'b0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load_priority();
    test_load_reject();
    test_modulus60();
    test_reset_mid_count();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
